// File: rtl/membus_arbiter_if.sv
// Shared device-bus bundle: two master request/response channels, the device side and arbiter status.
// slave is the arbiter's view; master is the view of whoever drives the requests and models the device.
interface membus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          dev_read;
  logic          dev_write;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata;
  logic [DW-1:0] dev_rdata;

  logic          owner;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output dev_read, dev_write, dev_addr, dev_wdata,
    input  dev_rdata,
    output owner, busy
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  dev_read, dev_write, dev_addr, dev_wdata,
    output dev_rdata,
    input  owner, busy
  );

endinterface

// File: rtl/membus_arbiter.sv
// Two-master arbiter for the device bus: round-robin with bounded lock bursts, all outputs registered.
// Grant at the sampling edge, device strobe the next cycle, ack the cycle after; a losing request stays pending.
module membus_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  membus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t        state;
  state_t        state_nxt;

  logic          grant;
  logic          win;
  logic          win_we;
  logic          win_lock;
  logic          other_req;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  logic          read_q,  read_nxt;
  logic          write_q, write_nxt;
  logic          ack0_q,  ack0_nxt;
  logic          ack1_q,  ack1_nxt;
  logic          owner_q, owner_nxt;
  logic          busy_q,  busy_nxt;
  logic          we_l,    we_nxt;
  logic          lock_l,  lock_nxt;
  logic [3:0]    burst_cnt, burst_nxt;
  logic [AW-1:0] addr_q,  addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic [DW-1:0] rdata_q, rdata_nxt;

  assign win_we    = win ? bus.m1_we    : bus.m0_we;
  assign win_lock  = win ? bus.m1_lock  : bus.m0_lock;
  assign win_addr  = win ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
  assign other_req = win ? bus.m0_req   : bus.m1_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The owner keeps the bus on a tie only while its last access was locked and its burst budget remains.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = 1'b0;
    unique case (state)
      IDLE: begin
        grant = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
          win = (lock_l && (burst_cnt < BURST_MAX)) ? owner_q : ~owner_q;
        end else begin
          win = bus.m1_req;
        end
        if (grant) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_nxt  = 1'b0;
    write_nxt = 1'b0;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    owner_nxt = owner_q;
    we_nxt    = we_l;
    lock_nxt  = lock_l;
    burst_nxt = burst_cnt;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata_q;
    unique case (state)
      IDLE: begin
        if (grant) begin
          owner_nxt = win;
          we_nxt    = win_we;
          lock_nxt  = win_lock;
          addr_nxt  = win_addr;
          wdata_nxt = win_wdata;
          read_nxt  = ~win_we;
          write_nxt = win_we;
          busy_nxt  = 1'b1;
          // Bursts only count while the other master is actually waiting.
          if (!other_req) begin
            burst_nxt = 4'd0;
          end else if ((win == owner_q) && win_lock) begin
            burst_nxt = burst_cnt + 4'd1;
          end else begin
            burst_nxt = 4'd1;
          end
        end
      end
      ACCESS: begin
        rdata_nxt = we_l ? '0 : bus.dev_rdata;
        ack0_nxt  = ~owner_q;
        ack1_nxt  = owner_q;
        busy_nxt  = 1'b1;
      end
      RESP: begin
        busy_nxt = 1'b0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      owner_q   <= 1'b1;
      busy_q    <= 1'b0;
      we_l      <= 1'b0;
      lock_l    <= 1'b0;
      burst_cnt <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      read_q    <= read_nxt;
      write_q   <= write_nxt;
      ack0_q    <= ack0_nxt;
      ack1_q    <= ack1_nxt;
      owner_q   <= owner_nxt;
      busy_q    <= busy_nxt;
      we_l      <= we_nxt;
      lock_l    <= lock_nxt;
      burst_cnt <= burst_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      rdata_q   <= rdata_nxt;
    end
  end

  assign bus.dev_read  = read_q;
  assign bus.dev_write = write_q;
  assign bus.dev_addr  = addr_q;
  assign bus.dev_wdata = wdata_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m0_rdata  = rdata_q;
  assign bus.m1_rdata  = rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;

  strobe_exclusive: assert property (@(posedge clk) !(read_q && write_q));
  strobe_in_access: assert property (@(posedge clk) (read_q || write_q) |-> (state == ACCESS));
  ack_exclusive:    assert property (@(posedge clk) !(ack0_q && ack1_q));

endmodule
